// File: rtl/nbit_countdown_chain_pkg.sv
// Shared definitions for the nbit_countdown_chain timer.
//   state_t     : controller state encoding (IDLE, RUN, DONE)
//   chain_width : total chain width from per-stage width and stage count
package nbit_countdown_chain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned chain_width(input int unsigned counter_size,
                                                input int unsigned num_of_counters);
        return counter_size * num_of_counters;
    endfunction

endpackage

// File: rtl/nbit_countdown_chain_if.sv
// Load/control/status bundle for nbit_countdown_chain.
//   load_valid, load_value : load request and W-bit count (stage 0 in LSBs)
//   load_ready             : load accepted when high together with load_valid
//   pause, abort           : run control
//   out_count, busy, done  : chain value and status
// master modport drives requests; slave modport is the timer side.
interface nbit_countdown_chain_if
    import nbit_countdown_chain_pkg::*;
#(
    parameter int unsigned W = chain_width(16, 4)
);
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_value;
    logic         pause;
    logic         abort;
    logic [W-1:0] out_count;
    logic         busy;
    logic         done;

    modport master (
        output load_valid, load_value, pause, abort,
        input  load_ready, out_count, busy, done
    );

    modport slave (
        input  load_valid, load_value, pause, abort,
        output load_ready, out_count, busy, done
    );
endinterface

// File: rtl/nbit_down_counter.sv
// One stage of the borrow-chained down-counter.
//   clk, reset  : clock, synchronous active-high reset (count -> 0)
//   load        : parallel load of load_value (has priority over enable)
//   enable      : decrement this cycle; 0 wraps to all-ones
//   count       : current stage value
//   borrow_out  : enable & (count == 0), enables the next stage
module nbit_down_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             borrow_out
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (enable)
            count <= count - WIDTH'(1);
    end

    assign borrow_out = enable & (count == '0);

endmodule

// File: rtl/nbit_countdown_chain.sv
// Loadable cascaded down-counter used as a long interval timer.
//   clk, reset : clock, synchronous active-high reset
//   bus        : nbit_countdown_chain_if.slave (load handshake, pause,
//                abort, out_count, busy, done)
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to restart the count
// from the last loaded value after every done pulse instead of idling.
module nbit_countdown_chain
    import nbit_countdown_chain_pkg::*;
#(
    parameter int unsigned COUNTER_SIZE    = 16,
    parameter int unsigned NUM_OF_COUNTERS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    nbit_countdown_chain_if.slave bus
);

    localparam int unsigned W = chain_width(COUNTER_SIZE, NUM_OF_COUNTERS);

    state_t state;
    state_t state_next;
    logic   busy_q;
    logic   done_q;
    logic   ready_q;

    logic                       accept;
    logic                       clear;
    logic                       reload;
    logic                       load;
    logic [W-1:0]               load_data;
    logic [W-1:0]               count;
    logic [NUM_OF_COUNTERS:0]   enable;

    assign accept    = (state == IDLE) & bus.load_valid;
    assign clear     = (state != IDLE) & bus.abort;
    assign enable[0] = (state == RUN) & ~bus.pause & ~bus.abort;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [W-1:0] reload_value;

    always_ff @(posedge clk) begin
        if (reset)
            reload_value <= '0;
        else if (accept)
            reload_value <= bus.load_value;
    end

    assign reload = (state == DONE) & ~bus.abort;
`else
    assign reload = 1'b0;
`endif

    // accept and clear are exclusive (IDLE vs not IDLE); abort forces zero.
    always_comb begin
        load      = accept | clear | reload;
        load_data = '0;
        if (accept)
            load_data = bus.load_value;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        else if (reload)
            load_data = reload_value;
`endif
    end

    for (genvar j = 0; j < NUM_OF_COUNTERS; j++) begin : g_stage
        nbit_down_counter #(
            .WIDTH (COUNTER_SIZE)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .load_value (load_data[j*COUNTER_SIZE +: COUNTER_SIZE]),
            .enable     (enable[j]),
            .count      (count[j*COUNTER_SIZE +: COUNTER_SIZE]),
            .borrow_out (enable[j+1])
        );
    end

    // RUN never holds a zero count, so the top stage must never borrow.
    no_chain_underflow: assert property (@(posedge clk) disable iff (reset)
        !enable[NUM_OF_COUNTERS]);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept)
                      state_next = (bus.load_value != '0) ? RUN : DONE;
            RUN:  if (bus.abort)
                      state_next = IDLE;
                  else if (enable[0] && count == W'(1))
                      state_next = DONE;
            DONE: if (bus.abort)
                      state_next = IDLE;
                  else
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                      state_next = (reload_value != '0) ? RUN : DONE;
`else
                      state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // Status flags are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_next;
            busy_q  <= (state_next == RUN);
            done_q  <= (state_next == DONE);
            ready_q <= (state_next == IDLE);
        end
    end

    assign bus.out_count  = count;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.load_ready = ready_q;

endmodule

// File: tb/tb_nbit_countdown_chain.sv
module tb_nbit_countdown_chain;

    localparam int unsigned CS = 4;
    localparam int unsigned N  = 2;
    localparam int unsigned W  = CS * N;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    nbit_countdown_chain_if #(.W(W)) bus();

    nbit_countdown_chain #(
        .COUNTER_SIZE    (CS),
        .NUM_OF_COUNTERS (N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int unsigned  cyc;
        logic [W-1:0] cnt;
        logic         busy;
        logic         done;
        logic         ready;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned done_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expected cycle entry and every done pulse.
    exp_t        e;
    int unsigned d;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL trace_missed expected_cycle=%0d seen_at=%0d", e.cyc, cyc);
            end else if ({bus.out_count, bus.busy, bus.done, bus.load_ready} !==
                         {e.cnt, e.busy, e.done, e.ready}) begin
                failures++;
                $display("FAIL trace cyc=%0d got cnt=%h busy=%b done=%b ready=%b want cnt=%h busy=%b done=%b ready=%b",
                         cyc, bus.out_count, bus.busy, bus.done, bus.load_ready,
                         e.cnt, e.busy, e.done, e.ready);
            end
        end
        if (bus.done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                failures++;
                $display("FAIL done_spurious cyc=%0d got done=1 want no pulse", cyc);
            end else begin
                d = done_q.pop_front();
                if (d != cyc) begin
                    failures++;
                    $display("FAIL done_time got cyc=%0d want cyc=%0d", cyc, d);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected observable outputs after the next clock edge.
    task automatic push_exp(input logic [W-1:0] c, input logic b, input logic dn, input logic r);
        exp_t x;
        x.cyc = cyc + 1; x.cnt = c; x.busy = b; x.done = dn; x.ready = r;
        exp_q.push_back(x);
        if (dn) done_q.push_back(cyc + 1);
    endtask

    task automatic idle_cycle(input bit lv_rand);
        bus.load_valid = lv_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.load_value = W'($urandom);
        bus.abort      = 1'($urandom_range(0, 1));
        bus.pause      = 1'($urandom_range(0, 1));
        push_exp('0, 1'b0, 1'b0, 1'b1);
        step();
    endtask

    // Reference: remaining count drops by one per unpaused cycle; abort clears.
    task automatic countdown(input logic [W-1:0] v, input logic [31:0] pmask,
                             input int abort_rem, input bit rnd, output bit aborted);
        int unsigned rem = v;
        int unsigned k = 0;
        bit pa;
        aborted = 1'b0;
        while (rem != 0) begin
            bus.load_valid = 1'($urandom_range(0, 1));
            bus.load_value = W'($urandom);
            pa = rnd ? ($urandom_range(0, 3) == 0) : pmask[k % 32];
            k++;
            bus.pause = pa;
            bus.abort = (int'(rem) == abort_rem);
            if (bus.abort) begin
                push_exp('0, 1'b0, 1'b0, 1'b1);
                step();
                bus.abort = 1'b0;
                aborted = 1'b1;
                return;
            end
            if (!pa) rem--;
            push_exp(W'(rem), rem != 0, rem == 0, 1'b0);
            step();
        end
    endtask

    task automatic do_load(input logic [W-1:0] v, input logic [31:0] pmask,
                           input int abort_rem, input bit rnd);
        bit ab;
        bus.load_valid = 1'b1;
        bus.load_value = v;
        bus.abort      = 1'($urandom_range(0, 1));
        bus.pause      = 1'($urandom_range(0, 1));
        push_exp(v, v != 0, v == 0, 1'b0);
        step();
        countdown(v, pmask, abort_rem, rnd, ab);
        if (!ab) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            for (int r = 0; r < 2; r++) begin
                bus.load_valid = 1'($urandom_range(0, 1));
                bus.abort = 1'b0;
                bus.pause = 1'b0;
                push_exp(v, v != 0, v == 0, 1'b0);
                step();
                countdown(v, '0, -1, 1'b0, ab);
            end
            bus.abort = 1'b1;
            push_exp('0, 1'b0, 1'b0, 1'b1);
            step();
            bus.abort = 1'b0;
`else
            idle_cycle(1'b0);
`endif
        end
    endtask

    initial begin
        int ar;
        logic [W-1:0] v;
        reset          = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_value = 8'hA5;
        bus.pause      = 1'b0;
        bus.abort      = 1'b0;
        push_exp('0, 1'b0, 1'b0, 1'b1);
        step();
        push_exp('0, 1'b0, 1'b0, 1'b1);
        step();
        reset = 1'b0;
        idle_cycle(1'b0);

        do_load(8'h05, '0, -1, 1'b0);
        idle_cycle(1'b0);
        do_load(8'h10, '0, -1, 1'b0);
        do_load(8'h00, '0, -1, 1'b0);
        do_load(8'h03, 32'b110, -1, 1'b0);
        do_load(8'h04, '0, 1, 1'b0);
        idle_cycle(1'b0);

        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle(1'b0);
            v  = (i % 3 == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 20));
            ar = (v != 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, v)) : -1;
            do_load(v, '0, ar, 1'b1);
        end

        // Reset in the middle of a run returns everything to idle.
        bus.load_valid = 1'b1;
        bus.load_value = 8'h30;
        push_exp(8'h30, 1'b1, 1'b0, 1'b0);
        step();
        bus.load_valid = 1'b0;
        bus.pause = 1'b0;
        bus.abort = 1'b0;
        push_exp(8'h2F, 1'b1, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        push_exp('0, 1'b0, 1'b0, 1'b1);
        step();
        reset = 1'b0;
        idle_cycle(1'b0);

        step();
        step();
        checks++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            failures++;
            $display("FAIL leftover got trace=%0d done=%0d want 0 0", exp_q.size(), done_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
